// File: rtl/matrix_acc_drain_pkg.sv
// Shared constants for the matrix accumulator / drain block.
// The opcode values sit next to the existing matrix opcodes and do not
// collide with them.
package matrix_acc_drain_pkg;

    localparam int OPC_W = 4;
    localparam int IDX_W = 2;

    localparam logic [OPC_W-1:0] MATRIX_MUL   = 4'h1;
    localparam logic [OPC_W-1:0] MATRIX_CLR   = 4'h6;
    localparam logic [OPC_W-1:0] MATRIX_DRAIN = 4'h7;

endpackage

// File: rtl/matrix_acc_drain_if.sv
// Command, multiplier and drain-stream signals of the accumulator block.
// master: execute-stage side, slave: matrix_acc_drain.
interface matrix_acc_drain_if #(
    parameter int N_ROWS = 4,
    parameter int ROW_W  = 32
);
    logic                      cmd_valid;
    logic                      cmd_ready;
    logic [3:0]                mul_ctrl;
    logic                      drain_clr;
    logic [N_ROWS*ROW_W-1:0]   mac_result;
    logic [N_ROWS*ROW_W-1:0]   acc_o;
    logic                      out_valid;
    logic                      out_ready;
    logic [ROW_W-1:0]          out_data;
    logic [1:0]                out_idx;
    logic                      out_last;
    logic                      busy;
    logic                      done;

    modport master (
        output cmd_valid, mul_ctrl, drain_clr, mac_result, out_ready,
        input  cmd_ready, acc_o, out_valid, out_data, out_idx, out_last, busy, done
    );

    modport slave (
        input  cmd_valid, mul_ctrl, drain_clr, mac_result, out_ready,
        output cmd_ready, acc_o, out_valid, out_data, out_idx, out_last, busy, done
    );
endinterface

// File: rtl/matrix_row_streamer.sv
// Snapshots the accumulator rows on a load strobe and streams them out one
// row per handshake, then pulses done for one cycle.
module matrix_row_streamer
    import matrix_acc_drain_pkg::*;
#(
    parameter int N_ROWS = 4,
    parameter int ROW_W  = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    load_i,
    input  logic [N_ROWS*ROW_W-1:0] rows_i,
    input  logic                    out_ready_i,
    output logic                    out_valid_o,
    output logic [ROW_W-1:0]        out_data_o,
    output logic [IDX_W-1:0]        out_idx_o,
    output logic                    out_last_o,
    output logic                    busy_o,
    output logic                    done_o
);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_DRAIN = 1'b1
    } drain_state_e;

    drain_state_e     state_q, state_d;
    logic [IDX_W-1:0] rcnt_q, rcnt_d;
    logic             done_q, done_d;
    logic [ROW_W-1:0] shadow_q [N_ROWS];

    // A load is only honoured in IDLE, so the snapshot never changes mid-drain.
    generate
        for (genvar gi = 0; gi < N_ROWS; gi++) begin : g_shadow
            // Capture row gi of the accumulator when a drain starts.
            always_ff @(posedge clk) begin
                if (rst) begin
                    shadow_q[gi] <= '0;
                end else if (load_i && (state_q == ST_IDLE)) begin
                    shadow_q[gi] <= rows_i[gi*ROW_W +: ROW_W];
                end
            end
        end
    endgenerate

    // FSM state, row counter and done pulse registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            rcnt_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rcnt_q  <= rcnt_d;
            done_q  <= done_d;
        end
    end

    // Next state and stream outputs; outputs read zero outside a drain.
    always_comb begin
        state_d     = state_q;
        rcnt_d      = rcnt_q;
        done_d      = 1'b0;
        out_valid_o = 1'b0;
        out_data_o  = '0;
        out_idx_o   = '0;
        out_last_o  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (load_i) begin
                    state_d = ST_DRAIN;
                    rcnt_d  = '0;
                end
            end
            ST_DRAIN: begin
                out_valid_o = 1'b1;
                out_data_o  = shadow_q[rcnt_q];
                out_idx_o   = rcnt_q;
                out_last_o  = (rcnt_q == IDX_W'(N_ROWS - 1));
                if (out_ready_i) begin
                    rcnt_d = rcnt_q + 1'b1;
                    if (out_last_o) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign busy_o = (state_q == ST_DRAIN);
    assign done_o = done_q;

endmodule

// File: rtl/matrix_acc_drain.sv
// Accumulator state holder for the 4x4 int8 matrix unit: captures multiplier
// results, clears on command, and hands a snapshot to the row streamer on drain.
module matrix_acc_drain
    import matrix_acc_drain_pkg::*;
#(
    parameter int N_ROWS = 4,
    parameter int ROW_W  = 32
) (
    input  logic             clk,
    input  logic             rst,
    matrix_acc_drain_if.slave bus
);

    logic [ROW_W-1:0] acc_q [N_ROWS];
    logic [ROW_W-1:0] acc_d [N_ROWS];
    logic             busy;
    logic             cmd_fire;
    logic             fire_mul;
    logic             fire_zero;
    logic             fire_drain;

    // A drain cannot start while one is streaming; every other opcode
    // (including NOPs) is always taken.
    assign bus.cmd_ready = !busy || (bus.mul_ctrl != MATRIX_DRAIN);
    assign cmd_fire      = bus.cmd_valid && bus.cmd_ready;
    assign fire_mul      = cmd_fire && (bus.mul_ctrl == MATRIX_MUL);
    assign fire_drain    = cmd_fire && (bus.mul_ctrl == MATRIX_DRAIN);
    assign fire_zero     = (cmd_fire && (bus.mul_ctrl == MATRIX_CLR))
                         || (fire_drain && bus.drain_clr);

    generate
        for (genvar gi = 0; gi < N_ROWS; gi++) begin : g_acc
            // Row gi next value: multiplier result, zero, or hold.
            always_comb begin
                acc_d[gi] = acc_q[gi];
                if (fire_mul) begin
                    acc_d[gi] = bus.mac_result[gi*ROW_W +: ROW_W];
                end else if (fire_zero) begin
                    acc_d[gi] = '0;
                end
            end

            // Row gi accumulator register.
            always_ff @(posedge clk) begin
                if (rst) begin
                    acc_q[gi] <= '0;
                end else begin
                    acc_q[gi] <= acc_d[gi];
                end
            end

            assign bus.acc_o[gi*ROW_W +: ROW_W] = acc_q[gi];
        end
    endgenerate

    // The streamer snapshots acc_q (pre-clear value) on the drain edge.
    matrix_row_streamer #(
        .N_ROWS (N_ROWS),
        .ROW_W  (ROW_W)
    ) u_streamer (
        .clk         (clk),
        .rst         (rst),
        .load_i      (fire_drain),
        .rows_i      (bus.acc_o),
        .out_ready_i (bus.out_ready),
        .out_valid_o (bus.out_valid),
        .out_data_o  (bus.out_data),
        .out_idx_o   (bus.out_idx),
        .out_last_o  (bus.out_last),
        .busy_o      (busy),
        .done_o      (bus.done)
    );

    assign bus.busy = busy;

endmodule

// File: tb/tb_matrix_acc_drain.sv
// Directed bench for matrix_acc_drain: a command vector table for the
// accumulator path plus hand-written drain sequences.
module tb_matrix_acc_drain;
    import matrix_acc_drain_pkg::*;

    localparam logic [127:0] VA  = 128'h04040404_03030303_02020202_01010101;
    localparam logic [127:0] VB  = 128'h8899aabb_ccddeeff_00112233_44556677;
    localparam logic [127:0] V11 = 128'h11111111_11111111_11111111_11111111;
    localparam logic [127:0] VC  = 128'hdeadbeef_a5a5a5a5_7f808182_0000ff01;

    logic clk = 1'b0;
    logic rst;

    matrix_acc_drain_if #(.N_ROWS(4), .ROW_W(32)) bus ();

    matrix_acc_drain #(.N_ROWS(4), .ROW_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string        name;
        logic         vld;
        logic [3:0]   ctrl;
        logic [127:0] mac;
        logic [127:0] exp_acc;
    } vec_t;

    vec_t vecs [8];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Start a drain, then follow it row by row with the given ready pattern,
    // presenting (dctrl, dvalid, dmac) on the command port during the drain.
    task automatic run_drain(input logic clr, input logic [127:0] exp_rows,
                             input logic [3:0] pat, input logic [3:0] dctrl,
                             input logic dvalid, input logic [127:0] dmac);
        int idx;
        int cyc;
        bus.cmd_valid  = 1'b1;
        bus.mul_ctrl   = MATRIX_DRAIN;
        bus.drain_clr  = clr;
        chk("drain_accept_ready", 128'(bus.cmd_ready), 128'(1));
        tick();
        if (clr) chk("drain_clr_acc", bus.acc_o, 128'h0);
        bus.cmd_valid  = dvalid;
        bus.mul_ctrl   = dctrl;
        bus.mac_result = dmac;
        bus.drain_clr  = 1'b0;
        idx = 0;
        cyc = 0;
        while (idx < 4 && cyc < 40) begin
            bus.out_ready = pat[cyc % 4];
            #1;
            chk("drain_valid", 128'(bus.out_valid), 128'(1));
            chk("drain_busy", 128'(bus.busy), 128'(1));
            chk("drain_data", 128'(bus.out_data), 128'(exp_rows[idx*32 +: 32]));
            chk("drain_idx", 128'(bus.out_idx), 128'(idx));
            chk("drain_last", 128'(bus.out_last), 128'(idx == 3));
            chk("drain_no_done", 128'(bus.done), 128'(0));
            chk("drain_cmd_ready", 128'(bus.cmd_ready), 128'(dctrl != MATRIX_DRAIN));
            if (bus.out_ready) idx++;
            tick();
            cyc++;
        end
        if (idx < 4) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: got %0d rows expected 4", idx);
        end
        chk("done_pulse", 128'(bus.done), 128'(1));
        chk("done_valid_low", 128'(bus.out_valid), 128'(0));
        chk("done_busy_low", 128'(bus.busy), 128'(0));
        chk("done_data_zero", 128'(bus.out_data), 128'(0));
    endtask

    initial begin
        vecs[0] = '{"mul_a",      1'b1, MATRIX_MUL, VA, VA};
        vecs[1] = '{"nop",        1'b1, 4'h0,       VB, VA};
        vecs[2] = '{"mul_novalid",1'b0, MATRIX_MUL, VB, VA};
        vecs[3] = '{"mul_b",      1'b1, MATRIX_MUL, VB, VB};
        vecs[4] = '{"undef_op",   1'b1, 4'hf,       VA, VB};
        vecs[5] = '{"clr",        1'b1, MATRIX_CLR, VA, 128'h0};
        vecs[6] = '{"mul_b2",     1'b1, MATRIX_MUL, VB, VB};
        vecs[7] = '{"mul_a_b2b",  1'b1, MATRIX_MUL, VA, VA};

        rst            = 1'b1;
        bus.cmd_valid  = 1'b0;
        bus.mul_ctrl   = 4'h0;
        bus.drain_clr  = 1'b0;
        bus.mac_result = '0;
        bus.out_ready  = 1'b0;
        repeat (3) tick();
        rst = 1'b0;

        // Reset state
        chk("rst_acc", bus.acc_o, 128'h0);
        chk("rst_valid", 128'(bus.out_valid), 128'(0));
        chk("rst_data", 128'(bus.out_data), 128'(0));
        chk("rst_idx", 128'(bus.out_idx), 128'(0));
        chk("rst_last", 128'(bus.out_last), 128'(0));
        chk("rst_busy", 128'(bus.busy), 128'(0));
        chk("rst_done", 128'(bus.done), 128'(0));
        chk("rst_cmd_ready", 128'(bus.cmd_ready), 128'(1));

        // Command table, one command per cycle
        for (int i = 0; i < 8; i++) begin
            bus.cmd_valid  = vecs[i].vld;
            bus.mul_ctrl   = vecs[i].ctrl;
            bus.mac_result = vecs[i].mac;
            #1;
            chk({vecs[i].name, "_ready"}, 128'(bus.cmd_ready), 128'(1));
            tick();
            chk(vecs[i].name, bus.acc_o, vecs[i].exp_acc);
            chk({vecs[i].name, "_idle"}, 128'(bus.out_valid), 128'(0));
            $display("vector %0d %s acc_o=%h", i, vecs[i].name, bus.acc_o);
        end
        bus.cmd_valid = 1'b0;

        // Plain drain, ready held high
        run_drain(1'b0, VA, 4'b1111, 4'h0, 1'b0, '0);
        tick();
        chk("done_one_cycle", 128'(bus.done), 128'(0));
        chk("acc_after_drain", bus.acc_o, VA);
        $display("drain ready=1 done");

        // Drain with ready toggling 1,0,0,1
        run_drain(1'b0, VA, 4'b1001, 4'h0, 1'b0, '0);
        tick();
        $display("drain ready toggle done");

        // Drain with clear and MACs during the drain
        run_drain(1'b1, VA, 4'b1111, MATRIX_MUL, 1'b1, V11);
        bus.cmd_valid = 1'b0;
        chk("acc_after_clr_drain", bus.acc_o, V11);
        tick();
        $display("drain clr + mac done");

        // Second drain presented during a drain (first clears acc)
        bus.cmd_valid  = 1'b1;
        bus.mul_ctrl   = MATRIX_MUL;
        bus.mac_result = VC;
        tick();
        chk("mul_c", bus.acc_o, VC);
        run_drain(1'b1, VC, 4'b1101, MATRIX_DRAIN, 1'b1, '0);
        run_drain(1'b0, 128'h0, 4'b1111, 4'h0, 1'b0, '0);
        tick();
        $display("second drain done");

        // Reset mid-drain after row 1 handshake
        bus.cmd_valid  = 1'b1;
        bus.mul_ctrl   = MATRIX_MUL;
        bus.mac_result = VA;
        tick();
        bus.mul_ctrl  = MATRIX_DRAIN;
        bus.out_ready = 1'b1;
        tick();
        bus.cmd_valid = 1'b0;
        tick();
        tick();
        chk("pre_rst_idx", 128'(bus.out_idx), 128'(2));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_valid", 128'(bus.out_valid), 128'(0));
        chk("midrst_acc", bus.acc_o, 128'h0);
        chk("midrst_busy", 128'(bus.busy), 128'(0));
        chk("midrst_data", 128'(bus.out_data), 128'(0));
        for (int i = 0; i < 6; i++) begin
            chk("midrst_no_done", 128'(bus.done), 128'(0));
            tick();
        end
        $display("reset mid-drain done");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/matrix_acc_drain.md
# matrix_acc_drain

Accumulator state holder and result reader for the packed 4×4 int8 matrix multiply unit. It holds the four 32-bit accumulator rows that feed the multiplier's `M` input and captures the multiplier's four result rows on each MAC command. On a drain command it snapshots the accumulator and streams the rows out one per cycle over a valid/ready port toward writeback or store. It sits beside the multiplier in the execute stage.

## Interface
Parameters:
- `N_ROWS`, 4: accumulator rows; fixed at 4 in this revision.
- `ROW_W`, 32: row width, four packed 8-bit elements.

Ports:
- `clk` in 1: clock. One clock; all state updates on the rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `cmd_valid` in 1: a command is presented.
- `cmd_ready` out 1: the command is accepted when `cmd_valid && cmd_ready`.
- `mul_ctrl` in 4: command opcode. Decodes `MATRIX_MUL`, `MATRIX_CLR` and `MATRIX_DRAIN`; every other value is a NOP (accepted, no effect).
- `drain_clr` in 1: with `MATRIX_DRAIN`, also zeroes the accumulator.
- `mac_result` in N_ROWS*ROW_W: multiplier output; row r is `[r*32 +: 32]`.
- `acc_o` out N_ROWS*ROW_W: accumulator to the multiplier's `M`, same packing; a direct register output.
- `out_valid` out 1: drained row is valid.
- `out_ready` in 1: consumer accepts the row.
- `out_data` out ROW_W: drained row.
- `out_idx` out 2: index of the drained row.
- `out_last` out 1: high with row 3.
- `busy` out 1: drain in progress.
- `done` out 1: one-cycle pulse after the last row handshake.

## Operation
- Registers: `acc[0..3]`, `shadow[0..3]`, FSM state, row counter `rcnt` (2 bits).
- States: `IDLE` and `DRAIN`.
- `MATRIX_MUL` accepted: `acc[r] <= mac_result[r]` for all r.
  - The block does no arithmetic; the multiplier's mod-256 per-element wrap is passed through unchanged.
- `MATRIX_CLR` accepted: `acc[r] <= 0`.
- `MATRIX_DRAIN` accepted (only in `IDLE`):
  - `shadow <= acc`, `rcnt <= 0`, state becomes `DRAIN`.
  - If `drain_clr` is set, `acc <= 0` in the same edge; `shadow` still gets the pre-clear value.
- `cmd_ready = (state == IDLE) || (mul_ctrl != MATRIX_DRAIN)`.
  - MAC and CLR are accepted during a drain and modify only `acc`, never `shadow`.
  - DRAIN is stalled while draining.
- In `DRAIN`:
  - `out_valid = 1`, `out_data = shadow[rcnt]`, `out_idx = rcnt`, `out_last = (rcnt == 3)`.
  - On each handshake, `rcnt` increments.
  - On the handshake at `rcnt == 3`: state becomes `IDLE` and `done` pulses in the following cycle.
- `out_data`, `out_idx` and `out_last` are held stable while `out_valid && !out_ready`.
- `busy = (state == DRAIN)`.
- In `IDLE`: `out_valid = 0`, and `out_data`, `out_idx`, `out_last` read as 0.

## Timing
- Reset values: `acc` = 0, `shadow` = 0, state `IDLE`, `rcnt` = 0, `out_valid` = 0, `out_data` = 0, `out_idx` = 0, `out_last` = 0, `busy` = 0, `done` = 0.
  - `cmd_ready` follows its equation and is 1 in `IDLE`.
- MAC accepted in cycle t: `acc_o` shows the new value from t+1. Back-to-back MACs update every cycle.
- DRAIN accepted in cycle t: `out_valid` is high from t+1 with row 0.
  - With `out_ready` held high, rows 0..3 appear in t+1..t+4 and `done` pulses at t+5.
  - Minimum spacing between accepted DRAINs is 5 cycles. In the cycle of the last handshake the state is still `DRAIN`, so a new DRAIN is accepted at the earliest in the next cycle.
- A MAC in the same cycle a DRAIN is accepted is impossible, since there is one opcode per cycle.
- A MAC in the cycle after a DRAIN is accepted does not alter `shadow`.
- `rst` asserted mid-drain: the remaining rows are discarded and all registers return to their reset values on that edge. No `done` pulse follows.
- All outputs are registered or depend only on registers, except `cmd_ready`, which depends on state and `mul_ctrl`.

## Structure
- The opcodes `MATRIX_MUL`, `MATRIX_CLR` and `MATRIX_DRAIN` are shared constants in `define.vh`, next to the existing matrix opcodes. The two new values must not collide with existing ones.
- The FSM state encoding is local to this module.
- One natural sub-module: `matrix_row_streamer`.
  - It owns the shadow, `rcnt` and the valid/ready logic.
  - It takes a load strobe plus 4 rows and produces `out_*`, `busy` and `done`.
  - The top level keeps `acc` and command decode.

## Test plan
- Reset, then MAC with `mac_result` = {0x04040404, 0x03030303, 0x02020202, 0x01010101} → `acc_o` equals that value one cycle later.
- DRAIN with `out_ready` = 1 → rows 0x01010101, 0x02020202, 0x03030303, 0x04040404 appear on consecutive cycles with `out_idx` 0..3, `out_last` set on row 3, and `done` one cycle after row 3.
- DRAIN while `out_ready` toggles 1,0,0,1,… → each row is held stable during stalls, no row is skipped or repeated, and `done` follows the 4th handshake.
- DRAIN with `drain_clr` = 1, then MAC of 0x11111111 in every row during the drain → the drained rows are the old values; after `done`, `acc_o` = 0x11111111 in every row.
- Second DRAIN presented during a drain → `cmd_ready` = 0 until `IDLE`, then it is accepted and streams the current `acc`.
- `rst` pulsed after row 1 has been handshaken → `out_valid` = 0, `acc_o` = 0 and `busy` = 0 on the next cycle, and no `done` pulse.
